// File: rtl/vram_fill_arbiter.sv
// Arbitrates the character video RAM write port between CPU stores and the fill engine.
// The CPU has priority; the fill engine is guaranteed one slot per STARVE_LIMIT+1 cycles.
module vram_fill_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 8,
    parameter int VRAM_DEPTH   = 2000,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK_CPU,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_stall,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [11:0]       fill_len,
    input  logic [DATA_W-1:0] fill_byte,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              video_write_enable,
    output logic [ADDR_W-1:0] video_write_addr,
    output logic [DATA_W-1:0] video_write_data
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic [11:0]       DEPTH_LEN  = 12'(VRAM_DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(VRAM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(VRAM_DEPTH - 1);
    localparam logic [2:0]        LIMIT      = 3'(STARVE_LIMIT);

    state_t            state_r;
    logic [ADDR_W-1:0] f_addr_r;
    logic [11:0]       f_rem_r;
    logic [DATA_W-1:0] f_byte_r;
    logic [2:0]        starve_cnt_r;
    logic              cpu_grant_s;
    logic              fill_grant_s;

    // Per-cycle grant decision: CPU wins unless the fill engine has waited LIMIT slots.
    always_comb begin
        cpu_grant_s  = 1'b0;
        fill_grant_s = 1'b0;
        case (state_r)
            IDLE: begin
                cpu_grant_s = cpu_we;
            end
            FILL: begin
                if (cpu_we && (starve_cnt_r < LIMIT)) begin
                    cpu_grant_s = 1'b1;
                end else begin
                    fill_grant_s = 1'b1;
                end
            end
            default: begin
                cpu_grant_s  = 1'b0;
                fill_grant_s = 1'b0;
            end
        endcase
    end

    assign cpu_stall = (state_r == FILL) && cpu_we && !cpu_grant_s;
    assign fill_busy = (state_r == FILL);

    // Fill FSM, fill registers and the registered write port toward the display engine.
    always_ff @(posedge CLK_CPU or posedge reset) begin
        if (reset) begin
            state_r            <= IDLE;
            f_addr_r           <= '0;
            f_rem_r            <= 12'd0;
            f_byte_r           <= '0;
            starve_cnt_r       <= 3'd0;
            fill_done          <= 1'b0;
            video_write_enable <= 1'b0;
            video_write_addr   <= '0;
            video_write_data   <= '0;
        end else begin
            video_write_enable <= cpu_grant_s | fill_grant_s;
            fill_done          <= 1'b0;
            if (cpu_grant_s) begin
                video_write_addr <= cpu_addr;
                video_write_data <= cpu_data;
            end else if (fill_grant_s) begin
                video_write_addr <= f_addr_r;
                video_write_data <= f_byte_r;
            end

            case (state_r)
                IDLE: begin
                    if (fill_start) begin
                        if (fill_len == 12'd0) begin
                            fill_done <= 1'b1;
                        end else begin
                            f_addr_r     <= (fill_base >= DEPTH_ADDR) ? '0 : fill_base;
                            f_rem_r      <= (fill_len > DEPTH_LEN) ? DEPTH_LEN : fill_len;
                            f_byte_r     <= fill_byte;
                            starve_cnt_r <= 3'd0;
                            state_r      <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (fill_grant_s) begin
                        starve_cnt_r <= 3'd0;
                        f_addr_r     <= (f_addr_r == LAST_ADDR) ? '0 : f_addr_r + 1'b1;
                        f_rem_r      <= f_rem_r - 12'd1;
                        // Last cell: done lines up with the write leaving the output register.
                        if (f_rem_r == 12'd1) begin
                            fill_done <= 1'b1;
                            state_r   <= IDLE;
                        end
                    end else begin
                        starve_cnt_r <= starve_cnt_r + 3'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_fill_arbiter.sv
// Randomized and directed bench for vram_fill_arbiter against a queue-based model
// that expands each fill into its list of target cells.
module tb_vram_fill_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_stall;
    logic        fill_start;
    logic [10:0] fill_base;
    logic [11:0] fill_len;
    logic [7:0]  fill_byte;
    logic        fill_busy;
    logic        fill_done;
    logic        video_write_enable;
    logic [10:0] video_write_addr;
    logic [7:0]  video_write_data;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining fill cells as a queue of addresses.
    int fill_q[$];
    int fbyte_m   = 0;
    int starve_m  = 0;
    int exp_addr  = 0;
    int exp_data  = 0;
    int last_stall = 0;
    int wr_seen   = 0;
    int hold_addr = 0;
    int hold_data = 0;

    vram_fill_arbiter dut (
        .CLK_CPU            (clk),
        .reset              (reset),
        .cpu_we             (cpu_we),
        .cpu_addr           (cpu_addr),
        .cpu_data           (cpu_data),
        .cpu_stall          (cpu_stall),
        .fill_start         (fill_start),
        .fill_base          (fill_base),
        .fill_len           (fill_len),
        .fill_byte          (fill_byte),
        .fill_busy          (fill_busy),
        .fill_done          (fill_done),
        .video_write_enable (video_write_enable),
        .video_write_addr   (video_write_addr),
        .video_write_data   (video_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        fill_q.delete();
        starve_m   = 0;
        exp_addr   = 0;
        exp_data   = 0;
        last_stall = 0;
    endtask

    // One clock cycle: drive inputs, check the stall/busy view, then the registered outputs.
    task automatic step(input int we, input int addr, input int data,
                        input int start, input int base, input int len, input int fb);
        int active, gc, gf, stall_e, done_n, n, b;
        @(negedge clk);
        cpu_we     = 1'(we);
        cpu_addr   = 11'(addr);
        cpu_data   = 8'(data);
        fill_start = 1'(start);
        fill_base  = 11'(base);
        fill_len   = 12'(len);
        fill_byte  = 8'(fb);
        #1;
        active  = (fill_q.size() > 0) ? 1 : 0;
        gc      = 0;
        gf      = 0;
        stall_e = 0;
        done_n  = 0;
        if (active != 0) begin
            if (we != 0 && starve_m < 4) begin
                gc = 1;
                starve_m++;
            end else begin
                gf = 1;
                stall_e = we;
                starve_m = 0;
            end
        end else begin
            gc = we;
            if (start != 0) begin
                if (len == 0) begin
                    done_n = 1;
                end else begin
                    n = (len > 2000) ? 2000 : len;
                    b = (base >= 2000) ? 0 : base;
                    for (int i = 0; i < n; i++) fill_q.push_back((b + i) % 2000);
                    fbyte_m  = fb;
                    starve_m = 0;
                end
            end
        end
        check_eq("cpu_stall", int'(cpu_stall), stall_e);
        check_eq("fill_busy_pre", int'(fill_busy), active);
        if (gc != 0) begin
            exp_addr = addr;
            exp_data = data;
        end else if (gf != 0) begin
            exp_addr = fill_q.pop_front();
            exp_data = fbyte_m;
            if (fill_q.size() == 0) done_n = 1;
        end
        last_stall = stall_e;
        @(posedge clk);
        #1;
        check_eq("wr_enable", int'(video_write_enable), gc | gf);
        check_eq("wr_addr", int'(video_write_addr), exp_addr);
        check_eq("wr_data", int'(video_write_data), exp_data);
        check_eq("fill_done", int'(fill_done), done_n);
        check_eq("fill_busy", int'(fill_busy), (fill_q.size() > 0) ? 1 : 0);
        if (video_write_enable) wr_seen++;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cpu_we = 1'b0;
        fill_start = 1'b0;
        #1;
        check_eq("rst_enable", int'(video_write_enable), 0);
        check_eq("rst_addr", int'(video_write_addr), 0);
        check_eq("rst_data", int'(video_write_data), 0);
        check_eq("rst_done", int'(fill_done), 0);
        check_eq("rst_busy", int'(fill_busy), 0);
        check_eq("rst_stall", int'(cpu_stall), 0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int we, a, d, st, ln;
        reset      = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = 11'd0;
        cpu_data   = 8'd0;
        fill_start = 1'b0;
        fill_base  = 11'd0;
        fill_len   = 12'd0;
        fill_byte  = 8'd0;
        model_clear();
        repeat (2) @(negedge clk);
        do_reset();

        // CPU pass-through, plain fill, wrap-around.
        step(1, 'h123, 'h41, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 10, 5, 'h20);
        idle(6);
        step(0, 0, 0, 1, 1998, 4, 'h2e);
        idle(5);

        // Starvation guard: CPU writes held for 20 cycles; stalled writes are re-presented.
        step(0, 0, 0, 1, 300, 3, 'h55);
        for (int i = 0; i < 20; i++) begin
            if (last_stall == 0) begin
                hold_addr = $urandom_range(0, 2047);
                hold_data = $urandom_range(0, 255);
            end
            step(1, hold_addr, hold_data, 0, 0, 0, 0);
        end
        idle(3);

        // Edge starts: zero length, clamped length, ignored restart.
        wr_seen = 0;
        step(0, 0, 0, 1, 50, 0, 'h11);
        idle(2);
        check_eq("len0_writes", wr_seen, 0);
        wr_seen = 0;
        step(0, 0, 0, 1, 2040, 3000, 'h7a);
        idle(2005);
        check_eq("clamp_writes", wr_seen, 2000);
        wr_seen = 0;
        step(0, 0, 0, 1, 100, 6, 'h33);
        idle(2);
        step(0, 0, 0, 1, 500, 10, 'h44);
        idle(8);
        check_eq("restart_writes", wr_seen, 6);

        // Reset mid-fill: three writes out, then abort.
        wr_seen = 0;
        step(0, 0, 0, 1, 700, 10, 'h66);
        idle(3);
        check_eq("pre_reset_writes", wr_seen, 3);
        do_reset();
        wr_seen = 0;
        idle(15);
        check_eq("post_reset_writes", wr_seen, 0);

        // Random traffic, honouring the hold-while-stalled rule.
        for (int i = 0; i < 3000; i++) begin
            if (last_stall != 0) begin
                we = 1;
            end else begin
                we = ($urandom_range(0, 99) < 60) ? 1 : 0;
                hold_addr = $urandom_range(0, 2047);
                hold_data = $urandom_range(0, 255);
            end
            a  = hold_addr;
            d  = hold_data;
            st = ($urandom_range(0, 29) == 0) ? 1 : 0;
            ln = ($urandom_range(0, 19) == 0) ? $urandom_range(1990, 4095)
                                               : $urandom_range(0, 40);
            step(we, a, d, st, $urandom_range(0, 2047), ln, $urandom_range(0, 255));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram_fill_arbiter.md
# vram_fill_arbiter

Shares the single write port of the character video RAM between CPU stores and a hardware fill engine, the block that clears the screen or blanks a line. It sits between the memory block's video write outputs and the display engine's `video_write_*` inputs. It arbitrates each cycle, with CPU priority and anti-starvation for the fill engine. All writes to the display engine are registered.

## Interface
- `ADDR_W`, 11: video RAM address width.
- `DATA_W`, 8: character width.
- `VRAM_DEPTH`, 2000: number of valid character cells, 80x25.
- `STARVE_LIMIT`, 4: maximum number of consecutive CPU grants while a fill is pending.

Ports (name, direction, width, meaning):
- `CLK_CPU` in 1: the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_we` in 1: CPU video write request.
- `cpu_addr` in ADDR_W: CPU write address.
- `cpu_data` in DATA_W: CPU write data.
- `cpu_stall` out 1: combinational. The CPU must hold `cpu_we`, `cpu_addr` and `cpu_data` while this is 1.
- `fill_start` in 1: single-cycle pulse that starts a fill.
- `fill_base` in ADDR_W: first cell of the fill.
- `fill_len` in 12: number of cells to fill.
- `fill_byte` in DATA_W: fill character.
- `fill_busy` out 1: high while in state FILL.
- `fill_done` out 1: single-cycle completion pulse.
- `video_write_enable` out 1: registered write strobe to the display engine.
- `video_write_addr` out ADDR_W: registered write address.
- `video_write_data` out DATA_W: registered write data.

## Operation
- The FSM has two states, IDLE and FILL. Reset puts it in IDLE.
- Fill registers:
  - `f_addr` (ADDR_W): next cell to write.
  - `f_rem` (12 bits): cells remaining.
  - `f_byte`: latched fill character.
  - `starve_cnt` (3 bits): consecutive CPU grants during the fill.
- IDLE:
  - Every `cpu_we` is granted. `cpu_stall` = 0.
  - `fill_start` with `fill_len` = 0: `fill_done` pulses the next cycle. The FSM stays in IDLE.
  - `fill_start` with `fill_len` ≠ 0: latch `f_addr` = `fill_base` and `f_byte` = `fill_byte`. Latch `f_rem` = min(`fill_len`, VRAM_DEPTH). Clear `starve_cnt` and go to FILL.
  - If `fill_base` ≥ VRAM_DEPTH, `f_addr` is latched as 0.
  - The CPU write in the same cycle as `fill_start` is still granted.
- FILL grant rule, evaluated each cycle:
  - `cpu_we` = 1 and `starve_cnt` < STARVE_LIMIT: grant the CPU, `starve_cnt` += 1, `cpu_stall` = 0.
  - `cpu_we` = 1 and `starve_cnt` = STARVE_LIMIT: grant the fill engine, `cpu_stall` = 1, `starve_cnt` = 0.
  - `cpu_we` = 0: grant the fill engine, `starve_cnt` = 0.
- A fill grant writes `f_byte` to `f_addr`, then decrements `f_rem`.
- Address advance: if `f_addr` = VRAM_DEPTH−1, `f_addr` wraps to 0; otherwise `f_addr` += 1.
- A fill grant with `f_rem` = 1 is the last write. The FSM returns to IDLE, and `fill_done` pulses in the cycle that write appears on `video_write_*`.
- `fill_start` during FILL is ignored. No queueing, no restart.
- CPU addresses are passed through unchecked. Writes to cells ≥ VRAM_DEPTH are the display engine's concern.
- Exactly one write is issued per granted cycle. A write is never dropped or duplicated.

## Timing
- Grant-to-output latency is 1 cycle: the grant in cycle N drives `video_write_*` in cycle N+1.
- `video_write_enable` = 0 in every cycle after a cycle with no grant. `video_write_addr` and `video_write_data` hold their last value.
- Fill throughput with `cpu_we` idle: 1 cell per cycle. Filling L cells takes L cycles from the first FILL cycle. `fill_done` is asserted in cycle L+1 after the `fill_start` cycle.
- Worst case under continuous CPU writes: the fill engine gets 1 slot in every STARVE_LIMIT+1 cycles.
- `fill_busy` rises the cycle after `fill_start` and falls in the same cycle `fill_done` is high.
- Reset values: `cpu_stall`, `fill_busy`, `fill_done` and `video_write_enable` = 0. `video_write_addr` and `video_write_data` = 0. `starve_cnt` = 0.
- Reset during FILL aborts the fill immediately. There is no `fill_done` pulse, and no further fill writes are issued after reset is released.

## Test plan
1. **CPU pass-through in IDLE.** `cpu_we` with addr 0x123 and data 0x41 → next cycle `video_write_enable` = 1, addr 0x123, data 0x41. `cpu_stall` stays 0.
2. **Plain fill.** `fill_start`, base 10, len 5, byte 0x20, no CPU traffic → writes to cells 10..14 on 5 consecutive cycles. `fill_done` is high together with the cell-14 write, and `fill_busy` falls in that cycle.
3. **Wrap-around.** base 1998, len 4 → writes to 1998, 1999, 0, 1, in that order.
4. **Starvation guard.** `fill_start` len 3, then `cpu_we` held high for 20 cycles → per 5 cycles, 4 CPU writes then 1 fill write, with `cpu_stall` = 1 exactly on the fill cycles. The fill completes after 15 cycles, and every stalled CPU write lands on the following cycle.
5. **Edge starts.**
   - len 0 → `fill_done` the next cycle, no writes.
   - len 3000 → clamped, exactly 2000 writes.
   - A second `fill_start` mid-fill → ignored, write count unchanged.
6. **Reset mid-fill.** Assert `reset` after 3 of 10 fill writes → all outputs go to 0 immediately. After release there are no further writes and no `fill_done` pulse.
